// File: rtl/keysched_pkg.sv
// Shared helpers and default key/decoy tables for the keyed schedule FSM.
// Used by keysched_counter and keyed_sched_fsm.
package keysched_pkg;

  localparam int DEF_NUM_SEG = 3;
  localparam int DEF_KEY_W   = 10;
  localparam int DEF_STATE_W = 4;

  // Slice i of each table belongs to segment i (slice 0 in the LSBs).
  localparam logic [DEF_NUM_SEG*DEF_KEY_W-1:0]   KEYS_DEF   = {10'd958, 10'd382, 10'd18};
  localparam logic [DEF_NUM_SEG*DEF_STATE_W-1:0] DECOYS_DEF = {4'd6, 4'd3, 4'd11};

  // Width of the segment index; a single segment still gets one bit.
  function automatic int seg_w(input int num_seg);
    return (num_seg <= 1) ? 1 : $clog2(num_seg);
  endfunction

  // Width of the schedule counter for a period of 'period' cycles.
  function automatic int cnt_w(input int period);
    return (period <= 1) ? 1 : $clog2(period);
  endfunction

endpackage

// File: rtl/keysched_counter.sv
// Schedule counter: counts 0..NUM_SEG*SEG_LEN-1 while step is high and
// derives the current segment index from the pre-edge count.
module keysched_counter
  import keysched_pkg::*;
#(
  parameter int NUM_SEG = 3,
  parameter int SEG_LEN = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       step,
  output logic [seg_w(NUM_SEG)-1:0]  seg_idx
);

  localparam int PERIOD = NUM_SEG * SEG_LEN;
  localparam int CNT_W  = cnt_w(PERIOD);
  localparam int SEG_W  = seg_w(NUM_SEG);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (step) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Division is widened to 32 bits so SEG_LEN never truncates to zero.
  assign seg_idx = SEG_W'(32'(cnt_q) / SEG_LEN);

endmodule

// File: rtl/keyed_sched_fsm.sv
// Keyed-schedule state register: a correct key for the current segment lets
// nx_state through, a wrong key loads that segment's decoy state instead.
// Optional build macro KEYSCHED_STICKY_EN: once a wrong key is seen, every
// later advance follows decoy states until reset.
module keyed_sched_fsm
  import keysched_pkg::*;
#(
  parameter int STATE_W     = 4,
  parameter int KEY_W       = 10,
  parameter int NUM_SEG     = 3,
  parameter int SEG_LEN     = 7,
  parameter int RESET_STATE = 1,
  parameter logic [NUM_SEG*KEY_W-1:0]   KEYS   = KEYS_DEF,
  parameter logic [NUM_SEG*STATE_W-1:0] DECOYS = DECOYS_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       step,
  input  logic [KEY_W-1:0]           keyinput,
  input  logic [STATE_W-1:0]         nx_state,
  output logic [STATE_W-1:0]         pr_state,
  output logic [seg_w(NUM_SEG)-1:0]  seg_idx,
  output logic                       key_ok,
  output logic                       lock_err
);

  localparam int SEG_W = seg_w(NUM_SEG);

  // Handshake: step is a plain enable, no ready; every step=1 cycle advances.
  keysched_counter #(
    .NUM_SEG (NUM_SEG),
    .SEG_LEN (SEG_LEN)
  ) u_counter (
    .clk     (clk),
    .rst     (rst),
    .step    (step),
    .seg_idx (seg_idx)
  );

  logic [KEY_W-1:0]   key_sel;
  logic [STATE_W-1:0] decoy_sel;

  always_comb begin
    key_sel   = '0;
    decoy_sel = '0;
    for (int i = 0; i < NUM_SEG; i++) begin
      if (seg_idx == SEG_W'(i)) begin
        key_sel   = KEYS[i*KEY_W +: KEY_W];
        decoy_sel = DECOYS[i*STATE_W +: STATE_W];
      end
    end
  end

  assign key_ok = (keyinput == key_sel);

  logic [STATE_W-1:0] pr_state_q;
  logic [STATE_W-1:0] pr_state_d;
  logic               lock_err_q;
  logic               lock_err_d;
  logic               take_decoy;

`ifdef KEYSCHED_STICKY_EN
  logic sticky_q;
  logic sticky_d;

  assign take_decoy = !key_ok || sticky_q;

  always_comb begin
    sticky_d = sticky_q;
    if (step && take_decoy) begin
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end
`else
  assign take_decoy = !key_ok;
`endif

  always_comb begin
    pr_state_d = pr_state_q;
    lock_err_d = lock_err_q;
    if (step) begin
      if (take_decoy) begin
        pr_state_d = decoy_sel;
        lock_err_d = 1'b1;
      end else begin
        pr_state_d = nx_state;
        lock_err_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pr_state_q <= STATE_W'(RESET_STATE);
      lock_err_q <= 1'b0;
    end else begin
      pr_state_q <= pr_state_d;
      lock_err_q <= lock_err_d;
    end
  end

  assign pr_state = pr_state_q;
  assign lock_err = lock_err_q;

endmodule

// File: doc/keyed_sched_fsm.md
KEYED_SCHED_FSM -- requirements
Module: keyed_sched_fsm

Interface
REQ-001 Parameter STATE_W, default 4: width of the state register.
REQ-002 Parameter KEY_W, default 10: width of the key input.
REQ-003 Parameter NUM_SEG, default 3: number of key segments per schedule period, range 1..8.
REQ-004 Parameter SEG_LEN, default 7: cycles per segment, range 1..64.
REQ-005 Parameter RESET_STATE, default 1: state loaded on reset.
REQ-006 Parameter KEYS, default {10'd958,10'd382,10'd18}: packed NUM_SEG*KEY_W; segment i uses slice i.
REQ-007 Parameter DECOYS, default {4'd6,4'd3,4'd11}: packed NUM_SEG*STATE_W; decoy state for segment i.
REQ-008 clk  in  1  single clock; all state changes on its rising edge.
REQ-009 rst  in  1  reset, synchronous and active-high.
REQ-010 step  in  1  advance enable; when low, counter, state and flags hold.
REQ-011 keyinput  in  KEY_W  applied key.
REQ-012 nx_state  in  STATE_W  next state from the external combinational FSM.
REQ-013 pr_state  out  STATE_W  registered present state.
REQ-014 seg_idx  out  $clog2(NUM_SEG) min 1  index of the current segment.
REQ-015 key_ok  out  1  combinational: keyinput equals the KEYS slice for seg_idx.
REQ-016 lock_err  out  1  registered: the last advancing cycle used a wrong key.

Function
REQ-017 Schedule counter SHALL be $clog2(NUM_SEG*SEG_LEN) bits and count 0..NUM_SEG*SEG_LEN-1 on each cycle with step=1, wrapping to 0 after the maximum.
REQ-018 seg_idx SHALL equal counter / SEG_LEN, computed from the pre-edge counter value.
REQ-019 On a cycle with step=1 and key_ok=1, pr_state SHALL load nx_state and lock_err SHALL clear.
REQ-020 On a cycle with step=1 and key_ok=0, pr_state SHALL load DECOYS[seg_idx] and lock_err SHALL set.
REQ-021 Key check and counter advance SHALL use the same pre-edge counter value, giving one-cycle latency from key to pr_state.
REQ-022 At the segment boundary (counter = k*SEG_LEN-1 to k*SEG_LEN), the cycle with the new counter value SHALL check against segment k.
REQ-023 At wrap-around, counter NUM_SEG*SEG_LEN-1 SHALL check the last segment and the next cycle SHALL check segment 0.
REQ-024 With step=0, key_ok SHALL still reflect the current segment and no register SHALL change.
REQ-025 NUM_SEG=1 SHALL give a static single-key lock; seg_idx SHALL be constant 0.

Reset
REQ-026 rst=1 at a clock edge SHALL set counter=0, pr_state=RESET_STATE, lock_err=0, and clear the sticky flag; this overrides step.
REQ-027 rst asserted mid-period SHALL restart the schedule at segment 0 on the first cycle after release.

Configuration
REQ-028 Macro KEYSCHED_STICKY_EN defined: after the first wrong-key advance, pr_state SHALL follow decoy states for every later advance until reset, even with a correct key; lock_err SHALL stay 1.
REQ-029 Macro KEYSCHED_STICKY_EN undefined: each advance SHALL be judged independently, per REQ-019 and REQ-020, and a correct key SHALL resume normal tracking on the next advance.

Structure
REQ-030 Package keysched_pkg SHALL hold the seg-index width function and default KEYS/DECOYS constants.
REQ-031 Sub-module keysched_counter SHALL implement the counter, seg_idx and step gating; the top SHALL hold the key compare, state mux and flags.

Verification
REQ-032 Defaults; reset, step=1, key=18, nx_state=2 for 7 cycles -> pr_state=2 each cycle, lock_err=0, seg_idx=0.
REQ-033 Cycle 7 (seg 1), key=18 -> pr_state=3, lock_err=1; key=382 on cycle 8 -> pr_state=nx_state (non-sticky build).
REQ-034 Full 21-cycle period with the correct key per segment (18/382/958) -> no lock_err; cycle 21 checks segment 0 again.
REQ-035 step=0 for 5 cycles mid-segment 2 -> counter, pr_state and lock_err frozen; schedule resumes at the same count.
REQ-036 Sticky build; one wrong key at cycle 3 -> pr_state=11, then 3 and 6 in later segments despite correct keys; rst clears to 1.
REQ-037 rst at counter=15 -> next cycle seg_idx=0, pr_state=1, and key 18 is required.
